// File: rtl/ai_player_controller_if.sv
// Groups the game-side signals of the AI player controller into one bundle.
// The master side is the game (drives frame/gamepad/obstacle/crash inputs, reads commands).
// The slave side is the controller (reads game state, drives registered button/crash/ai outputs).
interface ai_player_controller_if #(
    parameter int NUM_OBS = 4,
    parameter int W       = 10
);
    logic                   frame_tick;
    logic                   gamepad_is_present;
    logic                   gamepad_up;
    logic                   gamepad_down;
    logic [NUM_OBS*W-1:0]   obstacle_pos;
    logic [NUM_OBS-1:0]     obstacle_air;
    logic [2:0]             speed;
    logic                   crash;
    logic                   button_up;
    logic                   button_down;
    logic                   crash_out;
    logic                   ai_active;

    modport master (
        output frame_tick, gamepad_is_present, gamepad_up, gamepad_down,
        output obstacle_pos, obstacle_air, speed, crash,
        input  button_up, button_down, crash_out, ai_active
    );

    modport slave (
        input  frame_tick, gamepad_is_present, gamepad_up, gamepad_down,
        input  obstacle_pos, obstacle_air, speed, crash,
        output button_up, button_down, crash_out, ai_active
    );
endinterface

// File: rtl/ai_player_controller.sv
// Autopilot for a side-scroller: jumps ground obstacles, ducks flying ones, restarts after a crash.
// Latency: every output is registered, 1 clock from input change; no backpressure (frame-paced).
// Ports: clk, rst_n (async active-low); io.slave carries frame_tick, gamepad_*, obstacle_pos/air,
//        speed, crash in and button_up, button_down, crash_out, ai_active out.
module ai_player_controller #(
    parameter int CONV               = 0,
    parameter int NUM_OBS            = 4,
    parameter int PLAYER_OFFSET      = 6,
    parameter int OBSTACLE_THRESHOLD = 30,
    parameter int SPEED_SHIFT        = 2,
    parameter int JUMP_HOLD          = 8,
    parameter int RESTART_DELAY      = 60
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ai_player_controller_if.slave  io
);
    localparam int W    = 10 - CONV;
    localparam int LW   = W + 4;
    localparam int MAXC = (JUMP_HOLD > RESTART_DELAY) ? JUMP_HOLD : RESTART_DELAY;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {PLAY, JUMP, DUCK, CRASHED} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;
    logic            button_up_q, button_up_d;
    logic            button_down_q, button_down_d;
    logic            crash_out_q, crash_out_d;
    logic            ai_active_q, ai_active_d;

    logic [LW-1:0]   limit;
    logic [LW-1:0]   pos_ext;
    logic            ground_hit;
    logic            air_hit;

    // Reaction window grows with speed; the wide sum never truncates.
    assign limit = LW'(OBSTACLE_THRESHOLD) + (LW'(io.speed) << SPEED_SHIFT);

    always_comb begin
        ground_hit = 1'b0;
        air_hit    = 1'b0;
        pos_ext    = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            pos_ext = LW'(io.obstacle_pos[i*W +: W]);
            if (pos_ext > LW'(PLAYER_OFFSET) && pos_ext <= limit) begin
                if (io.obstacle_air[i]) air_hit    = 1'b1;
                else                    ground_hit = 1'b1;
            end
        end
    end

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        button_up_d   = button_up_q;
        button_down_d = button_down_q;
        crash_out_d   = crash_out_q;
        ai_active_d   = !io.gamepad_is_present;

        if (io.gamepad_is_present) begin
            // Human in control: mirror the pad, park the FSM so the AI resumes cleanly.
            state_d       = PLAY;
            cnt_d         = '0;
            button_up_d   = io.gamepad_up;
            button_down_d = io.gamepad_down;
            crash_out_d   = io.crash;
        end else begin
            case (state_q)
                PLAY: begin
                    button_up_d   = 1'b0;
                    button_down_d = 1'b0;
                    crash_out_d   = 1'b0;
                    if (io.crash) begin
                        state_d     = CRASHED;
                        crash_out_d = 1'b1;
                        cnt_d       = '0;
                    end else if (ground_hit) begin
                        state_d     = JUMP;
                        button_up_d = 1'b1;
                        cnt_d       = '0;
                    end else if (air_hit) begin
                        state_d       = DUCK;
                        button_down_d = 1'b1;
                    end
                end
                JUMP: begin
                    if (io.crash) begin
                        state_d       = CRASHED;
                        button_up_d   = 1'b0;
                        button_down_d = 1'b0;
                        crash_out_d   = 1'b1;
                        cnt_d         = '0;
                    end else if (io.frame_tick) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(JUMP_HOLD)) begin
                            state_d     = PLAY;
                            button_up_d = 1'b0;
                        end
                    end
                end
                DUCK: begin
                    if (io.crash) begin
                        state_d       = CRASHED;
                        button_up_d   = 1'b0;
                        button_down_d = 1'b0;
                        crash_out_d   = 1'b1;
                        cnt_d         = '0;
                    end else if (!air_hit) begin
                        // A waiting ground obstacle is picked up by PLAY next cycle.
                        state_d       = PLAY;
                        button_down_d = 1'b0;
                    end
                end
                CRASHED: begin
                    // Crash level is ignored here; only the restart timer matters.
                    button_up_d = 1'b0;
                    if (io.frame_tick) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(RESTART_DELAY)) begin
                            state_d     = PLAY;
                            crash_out_d = 1'b0;
                            button_up_d = 1'b1;   // one-clock restart press; PLAY clears it
                        end
                    end
                end
                default: state_d = PLAY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= PLAY;
            cnt_q         <= '0;
            button_up_q   <= 1'b0;
            button_down_q <= 1'b0;
            crash_out_q   <= 1'b0;
            ai_active_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            button_up_q   <= button_up_d;
            button_down_q <= button_down_d;
            crash_out_q   <= crash_out_d;
            ai_active_q   <= ai_active_d;
        end
    end

    assign io.button_up   = button_up_q;
    assign io.button_down = button_down_q;
    assign io.crash_out   = crash_out_q;
    assign io.ai_active   = ai_active_q;
endmodule

// File: tb/tb_ai_player_controller.sv
module tb_ai_player_controller;
    logic clk = 1'b0;
    logic rst_n;

    ai_player_controller_if #(.NUM_OBS(4), .W(10)) io();

    ai_player_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic up;
        logic dn;
        logic co;
        logic ai;
    } out_t;

    typedef struct packed {
        logic [39:0] pos;
        logic [3:0]  air;
        logic [2:0]  spd;
        logic        up;
        logic        dn;
    } vec_t;

    out_t exp_q[$];
    vec_t vecs[14];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic logic [39:0] pk(input int p0, input int p1, input int p2, input int p3);
        return {10'(p3), 10'(p2), 10'(p1), 10'(p0)};
    endfunction

    function automatic out_t mk(input logic u, input logic d, input logic c, input logic a);
        out_t o;
        o.up = u; o.dn = d; o.co = c; o.ai = a;
        return o;
    endfunction

    task automatic pop_cmp(input string nm);
        out_t got, e;
        got = {io.button_up, io.button_down, io.crash_out, io.ai_active};
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL %s: scoreboard empty, got up/dn/co/ai=%b", nm, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                mismatched++;
                $display("FAIL %s: got up/dn/co/ai=%b expected %b", nm, got, e);
            end
        end
    endtask

    // Drive one clock with optional frame tick; expected outputs are queued at drive time.
    task automatic cyc(input string nm, input logic tk, input out_t e);
        io.frame_tick = tk;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        io.frame_tick = 1'b0;
        pop_cmp(nm);
    endtask

    task automatic set_obs(input logic [39:0] p, input logic [3:0] a, input logic [2:0] s);
        io.obstacle_pos = p;
        io.obstacle_air = a;
        io.speed        = s;
    endtask

    // Hand control to the gamepad for a cycle, then back: returns the AI to a clean PLAY.
    task automatic park(input string nm);
        set_obs('0, '0, '0);
        io.crash = 1'b0;
        io.gamepad_up = 1'b0;
        io.gamepad_down = 1'b0;
        io.gamepad_is_present = 1'b1;
        cyc({nm, "_park"}, 1'b0, mk(0, 0, 0, 0));
        io.gamepad_is_present = 1'b0;
        cyc({nm, "_resume"}, 1'b0, mk(0, 0, 0, 1));
    endtask

    initial begin
        vecs[0]  = '{pos: pk(0, 0, 0, 0),    air: 4'b0000, spd: 3'd0, up: 0, dn: 0};
        vecs[1]  = '{pos: pk(0, 0, 30, 0),   air: 4'b0000, spd: 3'd0, up: 1, dn: 0};
        vecs[2]  = '{pos: pk(20, 0, 0, 0),   air: 4'b0001, spd: 3'd0, up: 0, dn: 1};
        vecs[3]  = '{pos: pk(31, 0, 0, 0),   air: 4'b0001, spd: 3'd0, up: 0, dn: 0};
        vecs[4]  = '{pos: pk(31, 0, 0, 0),   air: 4'b0001, spd: 3'd1, up: 0, dn: 1};
        vecs[5]  = '{pos: pk(0, 34, 0, 0),   air: 4'b0000, spd: 3'd1, up: 1, dn: 0};
        vecs[6]  = '{pos: pk(0, 35, 0, 0),   air: 4'b0000, spd: 3'd1, up: 0, dn: 0};
        vecs[7]  = '{pos: pk(6, 0, 0, 0),    air: 4'b0000, spd: 3'd0, up: 0, dn: 0};
        vecs[8]  = '{pos: pk(7, 0, 0, 0),    air: 4'b0000, spd: 3'd0, up: 1, dn: 0};
        vecs[9]  = '{pos: pk(25, 25, 0, 0),  air: 4'b0010, spd: 3'd0, up: 1, dn: 0};
        vecs[10] = '{pos: pk(0, 0, 0, 1023), air: 4'b0000, spd: 3'd7, up: 0, dn: 0};
        vecs[11] = '{pos: pk(0, 0, 0, 58),   air: 4'b1000, spd: 3'd7, up: 0, dn: 1};
        vecs[12] = '{pos: pk(0, 0, 0, 59),   air: 4'b1000, spd: 3'd7, up: 0, dn: 0};
        vecs[13] = '{pos: pk(0, 0, 0, 58),   air: 4'b0000, spd: 3'd7, up: 1, dn: 0};

        rst_n = 1'b0;
        io.frame_tick = 1'b0;
        io.gamepad_is_present = 1'b0;
        io.gamepad_up = 1'b0;
        io.gamepad_down = 1'b0;
        io.crash = 1'b0;
        set_obs('0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(mk(0, 0, 0, 0));
        pop_cmp("reset_state");
        rst_n = 1'b1;
        cyc("after_reset", 1'b0, mk(0, 0, 0, 1));

        // Window / priority table
        for (int i = 0; i < 14; i++) begin
            set_obs(vecs[i].pos, vecs[i].air, vecs[i].spd);
            cyc($sformatf("vec%0d", i), 1'b0, mk(vecs[i].up, vecs[i].dn, 0, 1));
            park($sformatf("vec%0d", i));
        end

        // Jump held exactly JUMP_HOLD ticks; hits ignored mid-jump
        set_obs(pk(0, 0, 30, 0), 4'b0000, 3'd0);
        cyc("jump_start", 1'b0, mk(1, 0, 0, 1));
        set_obs(pk(20, 0, 0, 0), 4'b0001, 3'd0);
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) set_obs('0, '0, '0);
            cyc($sformatf("jump_tick%0d", k), 1'b1, mk(k < 8, 0, 0, 1));
            cyc($sformatf("jump_idle%0d", k), 1'b0, mk(k < 8, 0, 0, 1));
        end

        // Duck on entry, release on exit, speed widens window, ground after duck
        set_obs(pk(20, 0, 0, 0), 4'b0001, 3'd0);
        cyc("duck_enter", 1'b0, mk(0, 1, 0, 1));
        cyc("duck_hold", 1'b1, mk(0, 1, 0, 1));
        set_obs(pk(5, 0, 0, 0), 4'b0001, 3'd0);
        cyc("duck_leave", 1'b0, mk(0, 0, 0, 1));
        set_obs(pk(31, 0, 0, 0), 4'b0001, 3'd0);
        cyc("duck_31_spd0", 1'b0, mk(0, 0, 0, 1));
        set_obs(pk(31, 0, 0, 0), 4'b0001, 3'd1);
        cyc("duck_31_spd1", 1'b0, mk(0, 1, 0, 1));
        set_obs(pk(31, 0, 0, 0), 4'b0000, 3'd1);
        cyc("duck_to_ground", 1'b0, mk(0, 0, 0, 1));
        cyc("ground_after_duck", 1'b0, mk(1, 0, 0, 1));
        park("duck_seq");

        // Crash during jump, crash level ignored, restart pulse after RESTART_DELAY ticks
        set_obs(pk(0, 0, 30, 0), 4'b0000, 3'd0);
        cyc("cj_jump", 1'b0, mk(1, 0, 0, 1));
        set_obs('0, '0, '0);
        cyc("cj_hold", 1'b0, mk(1, 0, 0, 1));
        io.crash = 1'b1;
        cyc("cj_crash", 1'b0, mk(0, 0, 1, 1));
        for (int k = 1; k <= 59; k++) begin
            if (k == 30) io.crash = 1'b0;
            cyc($sformatf("cj_wait%0d", k), 1'b1, mk(0, 0, 1, 1));
        end
        cyc("cj_restart", 1'b1, mk(1, 0, 0, 1));
        cyc("cj_pulse_end", 1'b0, mk(0, 0, 0, 1));
        cyc("cj_quiet", 1'b1, mk(0, 0, 0, 1));

        // Gamepad takeover mid-crash, then release onto an in-window air obstacle
        io.crash = 1'b1;
        cyc("gp_crash", 1'b0, mk(0, 0, 1, 1));
        io.crash = 1'b0;
        for (int k = 1; k <= 10; k++) cyc($sformatf("gp_wait%0d", k), 1'b1, mk(0, 0, 1, 1));
        io.gamepad_is_present = 1'b1;
        io.gamepad_up = 1'b1;
        cyc("gp_take_up", 1'b0, mk(1, 0, 0, 0));
        io.crash = 1'b1;
        cyc("gp_crash_follow", 1'b0, mk(1, 0, 1, 0));
        io.crash = 1'b0;
        io.gamepad_up = 1'b0;
        set_obs(pk(20, 0, 0, 0), 4'b0001, 3'd0);
        cyc("gp_obs_ignored", 1'b0, mk(0, 0, 0, 0));
        io.gamepad_is_present = 1'b0;
        cyc("gp_release_duck", 1'b0, mk(0, 1, 0, 1));
        park("gp_seq");

        // Async reset mid-crash count: outputs drop at once, no restart pulse afterwards
        io.crash = 1'b1;
        cyc("rst_crash", 1'b0, mk(0, 0, 1, 1));
        io.crash = 1'b0;
        for (int k = 1; k <= 30; k++) cyc($sformatf("rst_wait%0d", k), 1'b1, mk(0, 0, 1, 1));
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0));
        pop_cmp("rst_async");
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 70; k++) cyc($sformatf("rst_after%0d", k), 1'b1, mk(0, 0, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ai_player_controller.md
AI_PLAYER_CONTROLLER -- requirements
Module: ai_player_controller

Interface
- Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter CONV, default 0: position LSB index; position width W = 10-CONV.
REQ-002 The block SHALL have parameter NUM_OBS, default 4: number of obstacle channels (1..8).
REQ-003 The block SHALL have parameter PLAYER_OFFSET, default 6: positions less than or equal to this are behind the player.
REQ-004 The block SHALL have parameter OBSTACLE_THRESHOLD, default 30: base near edge of the reaction window.
REQ-005 The block SHALL have parameter SPEED_SHIFT, default 2: window widening per speed level, as a left shift of speed.
REQ-006 The block SHALL have parameter JUMP_HOLD, default 8: frames button_up is held per jump.
REQ-007 The block SHALL have parameter RESTART_DELAY, default 60: frames waited after a crash before restart.
- Ports (name, direction, width, meaning):
REQ-008 The block SHALL have port clk, input, 1: the single clock.
REQ-009 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-010 The block SHALL have port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-011 The block SHALL have port gamepad_is_present, input, 1: a human controller is attached.
REQ-012 The block SHALL have ports gamepad_up and gamepad_down, input, 1 each: human buttons.
REQ-013 The block SHALL have port obstacle_pos, input, NUM_OBS*W: packed positions; channel i occupies bits [(i+1)*W-1 : i*W].
REQ-014 The block SHALL have port obstacle_air, input, NUM_OBS: 1 = flying obstacle (requires a duck), 0 = ground obstacle (requires a jump).
REQ-015 The block SHALL have port speed, input, 3: game speed level.
REQ-016 The block SHALL have port crash, input, 1: collision flag from the game.
REQ-017 The block SHALL have ports button_up and button_down, output, 1 each, registered: commands to the game.
REQ-018 The block SHALL have port crash_out, output, 1, registered: crash state to the game.
REQ-019 The block SHALL have port ai_active, output, 1, registered: equals the registered value of !gamepad_is_present.

Function
REQ-020 Window limit SHALL be computed in W+4 bits as OBSTACLE_THRESHOLD + (speed << SPEED_SHIFT), with no truncation.
REQ-021 Channel i SHALL be in-window when pos_i > PLAYER_OFFSET and pos_i <= the window limit; any W-bit value is legal, with no wrap-around handling.
REQ-022 The block SHALL form ground_hit = OR over in-window channels with obstacle_air = 0, and air_hit = OR over in-window channels with obstacle_air = 1.
REQ-023 The FSM SHALL have states PLAY, JUMP, DUCK and CRASHED, and SHALL reset to PLAY.
REQ-024 In PLAY, priority SHALL be crash > ground_hit > air_hit.
REQ-025 In PLAY, crash SHALL cause a transition to CRASHED with crash_out=1 and both buttons 0.
REQ-026 In PLAY, ground_hit SHALL cause a transition to JUMP with button_up=1 and the frame counter cleared.
REQ-027 In PLAY, air_hit SHALL cause a transition to DUCK with button_down=1.
REQ-028 In PLAY with no event, both buttons SHALL be 0.
REQ-029 In JUMP, button_up SHALL stay 1 and the frame counter SHALL increment per frame_tick; on the tick making the count JUMP_HOLD, the FSM SHALL go to PLAY with button_up=0.
REQ-030 In JUMP, new hits SHALL be ignored.
REQ-031 In DUCK, button_down SHALL stay 1 while air_hit; when air_hit=0, button_down SHALL go to 0 and the FSM to PLAY.
REQ-032 In DUCK, ground_hit with air_hit=0 SHALL be handled in the following PLAY cycle.
REQ-033 In JUMP or DUCK, crash SHALL cause a transition to CRASHED, clearing both buttons, setting crash_out=1 and clearing the counter, taking priority over all else.
REQ-034 In CRASHED, the counter SHALL increment per frame_tick; on the tick making the count RESTART_DELAY, crash_out SHALL go to 0, button_up SHALL pulse 1 for exactly one clock, and the FSM SHALL go to PLAY.
REQ-035 In CRASHED, the crash level SHALL be ignored.
REQ-036 Response latency from input change to registered output SHALL be 1 clock.
REQ-037 The frame counter width SHALL be sized to hold max(JUMP_HOLD, RESTART_DELAY) and SHALL never wrap.
REQ-038 While gamepad_is_present=1, button_up, button_down and crash_out SHALL be the registered values of gamepad_up, gamepad_down and crash; the FSM SHALL be forced to PLAY and the counter cleared.
REQ-039 When gamepad_is_present falls, the AI SHALL resume from PLAY on the next cycle.
REQ-040 The gamepad_is_present override SHALL take effect mid-JUMP, mid-DUCK or mid-CRASHED within 1 clock.

Reset
REQ-041 On rst_n=0, asynchronously: button_up=0, button_down=0, crash_out=0, ai_active=0, state=PLAY, counter=0.
REQ-042 Deassertion mid-operation SHALL restart from PLAY with no pending jump or restart pulse.

Verification
REQ-043 Defaults, speed=0, channel 2 ground at pos 30 -> button_up=1 next clock, held exactly 8 frame_ticks, then 0.
REQ-044 Channel 0 air at pos 20, then moved to pos 5 -> button_down=1 one clock after entry, 0 one clock after pos 5; at pos 31 with speed=0 -> no response, with speed=1 (limit 34) -> duck.
REQ-045 Ground at 25 and air at 25 on the same cycle -> JUMP taken, button_down stays 0.
REQ-046 crash pulse during JUMP -> crash_out=1 and button_up=0 next clock; after 60 frame_ticks crash_out=0 and a single-clock button_up pulse occurs.
REQ-047 gamepad_is_present=1 mid-CRASHED with gamepad_up=1 -> button_up=1 and crash_out follows crash next clock, ai_active=0; on release, in-window obstacles are acted on in the next cycle.
REQ-048 rst_n asserted mid-count in CRASHED -> all outputs 0 immediately; after release, no restart pulse occurs.
